// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mul_pkg;

    localparam int MUL_WIDTH = 32;
    localparam int MUL_ITER  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/add_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [8:0]  cg;

    assign g     = a & b;
    assign p     = a ^ b;
    assign cg[0] = cin;

    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        logic grp_g;
        logic grp_p;

        assign c[B]   = cg[k];
        assign c[B+1] = g[B] | (p[B] & cg[k]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & cg[k]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & cg[k]);

        assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p = &p[B+3:B];
        assign cg[k+1] = grp_g | (grp_p & cg[k]);
    end

    assign sum  = p ^ c;
    assign cout = cg[8];

endmodule

// File: rtl/mul_seq.sv
// Sequential 32x32->64 multiplier: one add per clock over 32 iterations,
// signed or unsigned, with a start/done handshake toward HI/LO.
//
// state | meaning
// IDLE  | waiting for start; hi/lo hold the last product
// CALC  | one shift-and-add iteration per cycle, 32 cycles
// DONE  | product valid, done pulsed for one cycle
module mul_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int ITER  = MUL_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [4:0] LAST = 5'(ITER - 1);

    mul_state_e state_q, state_d;

    logic [WIDTH-1:0] m_q,   m_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] q_q,   q_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             sgn_q, sgn_d;

    logic             last_iter;
    logic             sub;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_z;
    logic             add_cout;
    logic             ext;

    assign last_iter = (cnt_q == LAST);

    // The final signed iteration has negative weight, so M is subtracted.
    assign sub     = sgn_q & last_iter;
    assign add_b   = q_q[0] ? (sub ? ~m_q : m_q) : '0;
    assign add_cin = q_q[0] & sub;

    add_32 u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_z),
        .cout (add_cout)
    );

    assign ext = sgn_q ? (acc_q[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout) : add_cout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == CALC);
        done = (state_q == DONE);
    end

    always_comb begin
        m_d   = m_q;
        acc_d = acc_q;
        q_d   = q_q;
        cnt_d = cnt_q;
        sgn_d = sgn_q;
        if (state_q == IDLE && start) begin
            m_d   = a;
            q_d   = b;
            acc_d = '0;
            cnt_d = '0;
            sgn_d = is_signed;
        end else if (state_q == CALC) begin
            acc_d = {ext, add_z[WIDTH-1:1]};
            q_d   = {add_z[0], q_q[WIDTH-1:1]};
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m_q   <= '0;
            acc_q <= '0;
            q_q   <= '0;
            cnt_q <= '0;
            sgn_q <= 1'b0;
        end else begin
            m_q   <= m_d;
            acc_q <= acc_d;
            q_q   <= q_d;
            cnt_q <= cnt_d;
            sgn_q <= sgn_d;
        end
    end

    assign hi = acc_q;
    assign lo = q_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed-vector bench for mul_seq: products, latency, ignored start, reset abort.
module tb_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;

    mul_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a product, wait for done (bounded), check latency and result.
    task automatic run_mul(input string tag, input logic sgn, input logic [31:0] op_a,
                           input logic [31:0] op_b, input logic [63:0] exp_p);
        int cycles;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; a = op_a; b = op_b;
        @(posedge clk); #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; is_signed = ~sgn;
        cycles = 1;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        while (!done && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk({tag, "_done_seen"}, 64'(done), 64'd1);
        chk({tag, "_latency"}, 64'(cycles), 64'd33);
        chk({tag, "_prod"}, {hi, lo}, exp_p);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {62'd0, busy, done}, 64'd0);
        chk({tag, "_hold"}, {hi, lo}, exp_p);
    endtask

    initial begin
        int busy_drops;
        int done_cnt;
        int cycles;
        n_checks = 0; n_fail = 0;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {60'd0, busy, done, |hi, |lo}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_mul("u_3x5",      1'b0, 32'd3,          32'd5,          64'h0000_0000_0000_000F);
        run_mul("u_max",      1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001);
        run_mul("s_m1",       1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);
        run_mul("s_m7x3",     1'b1, 32'hFFFF_FFF9,  32'd3,          64'hFFFF_FFFF_FFFF_FFEB);
        run_mul("s_3xm7",     1'b1, 32'd3,          32'hFFFF_FFF9,  64'hFFFF_FFFF_FFFF_FFEB);
        run_mul("s_minsq",    1'b1, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
        run_mul("s_minx1",    1'b1, 32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000);
        run_mul("u_minsq",    1'b0, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);

        // Second start mid-CALC must be ignored.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd1000; b = 32'd1000;
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 1; busy_drops = 0;
        while (!done && cycles < 40) begin
            if (cycles == 10) begin
                start = 1'b1; a = 32'd7; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
            if (!done && !busy) busy_drops++;
        end
        start = 1'b0;
        chk("ign_done_seen", 64'(done), 64'd1);
        chk("ign_latency", 64'(cycles), 64'd33);
        chk("ign_busy_drops", 64'(busy_drops), 64'd0);
        chk("ign_prod", {hi, lo}, 64'd1_000_000);
        @(posedge clk); #1;
        chk("ign_no_requeue", {62'd0, busy, done}, 64'd0);

        // Reset in the middle of CALC aborts with no done pulse.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; a = 32'd5; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk("abort_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_outputs", {60'd0, busy, done, |hi, |lo}, 64'd0);
        done_cnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) done_cnt++;
        end
        chk("abort_no_done", 64'(done_cnt), 64'd0);

        // Reset and start together: reset wins.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; a = 32'd4; b = 32'd4;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("rst_start_busy", 64'(busy), 64'd0);

        run_mul("u_2x2", 1'b0, 32'd2, 32'd2, 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Sequential 32×32 → 64-bit multiplier controller for the Mini-SRC datapath. It time-shares one 32-bit carry-lookahead adder over 32 shift-and-add iterations, one per clock. It supports signed (two's complement) and unsigned operands. It sits beside the ALU and delivers the product to the HI/LO register pair through a start/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand width; fixed at 32 because the adder is 32-bit.
- ITER, 32, iteration count; must equal WIDTH.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- is_signed  in  1  1 = two's complement, 0 = unsigned; sampled with start.
- a  in  32  multiplicand; sampled with start.
- b  in  32  multiplier; sampled with start.
- busy  out  1  high in CALC.
- done  out  1  one-cycle pulse when the product is valid.
- hi  out  32  product bits 63:32.
- lo  out  32  product bits 31:0.

## Operation
Registers:
- M (32): latched multiplicand.
- ACC (32): partial product, high half.
- Q (32): multiplier, shifting right; receives the low product bits.
- cnt (5)
- sgn (1)

States IDLE → CALC → DONE → IDLE:
- **IDLE**: when start=1, load M=a, Q=b, ACC=0, cnt=0, sgn=is_signed, then go to CALC. Otherwise hold all registers.
- **CALC**: each cycle drives the adder with A=ACC and Cin as listed below.
  - If Q[0]=0: B=0, Cin=0.
  - If Q[0]=1 and not (sgn and cnt=31): B=M, Cin=0.
  - If Q[0]=1 and sgn and cnt=31: B=~M, Cin=1. This subtracts M to correct the sign weight.
  - Extension bit: ext = sgn ? (ACC[31] ^ B[31] ^ Cout) : Cout.
  - Update: {ACC,Q} <= {ext, Z, Q[31:1]}; cnt <= cnt+1.
  - When cnt=31, go to DONE.
- **DONE**: done=1 for exactly one cycle, then go to IDLE.
- Outputs: hi=ACC and lo=Q, valid from the done cycle until the next accepted start. Contents during CALC are don't-care for consumers.
- start while in CALC or DONE is ignored and is not queued.
- Width rule: product is exact modulo 2^64, with no overflow indication.
  - Unsigned range: 0 to (2^32−1)^2.
  - Signed range: −2^62+2^31 to 2^62.

## Timing
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; M, cnt and sgn cleared.
- Start accepted at edge 0. busy is high for edges 1–32 (32 CALC cycles). done is high in the cycle after edge 32. The result is visible at that done cycle: latency 33 cycles from start to done.
- Back-to-back: start may be asserted in the cycle after done (IDLE); throughput is 1 product per 34 cycles.
- Reset asserted mid-CALC or in DONE aborts immediately: next state IDLE, outputs at reset values, no done pulse.
- reset and start in the same cycle: reset wins.
- Operand inputs are don't-care outside the start cycle.

## Structure
- Shared package mul_pkg holds:
  - state enum {IDLE, CALC, DONE}
  - constants MUL_WIDTH=32 and MUL_ITER=32
- One sub-module: the existing 32-bit CLA adder add_32, instantiated once. mul_seq adds no other arithmetic.
- The remaining RTL is the FSM, the 5-bit counter, operand/B-select muxing, ext logic and the shift register.

## Test plan
- Unsigned, a=3, b=5 → done exactly 33 cycles after start; hi=0x00000000, lo=0x0000000F.
- Unsigned, a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Signed with the same operands → hi=0x00000000, lo=0x00000001.
- Signed, a=0xFFFFFFF9 (−7), b=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Signed, a=3, b=0xFFFFFFF9 → same result (exercises the final subtract).
- Signed, a=b=0x80000000 → hi=0x40000000, lo=0x00000000. Signed, a=0x80000000, b=1 → hi=0xFFFFFFFF, lo=0x80000000.
- Pulse start again at cycle 10 with different operands → ignored; first product is delivered unchanged and busy is never interrupted.
- Reset at cycle 15 of CALC → next cycle busy=0, hi=lo=0, no done pulse. A new start (a=2, b=2) then gives lo=4 after 33 cycles.
